// File: rtl/hpf_coef_pkg.sv
// Shared types for the HPF coefficient responder: sample, coefficient and accumulator widths,
// register-select codes, FSM states and the signed multiply helper.
package hpf_coef_pkg;

  localparam int SAMPLE_W = 16;
  localparam int COEF_W   = 32;
  localparam int PROD_W   = COEF_W + SAMPLE_W;
  localparam int ACC_W    = PROD_W + 2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    SEL_B0      = 2'd0,
    SEL_B1      = 2'd1,
    SEL_A1      = 2'd2,
    SEL_ILLEGAL = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  typedef struct packed {
    coef_t b0;
    coef_t b1;
    coef_t a1;
  } coef_set_t;

  // One bit per coefficient: a set is complete when every bit is present.
  localparam logic [2:0] MASK_ALL = 3'b111;

  // Full-precision signed product; both operands are sign-extended before multiplying.
  function automatic prod_t mul(input coef_t c, input sample_t s);
    return prod_t'(c) * prod_t'(s);
  endfunction

endpackage

// File: rtl/hpf_coef_responder_if.sv
// Bus bundle between the HPF coefficient responder and its host: coefficient writes,
// run control, the sample stream and the status flags.
interface hpf_coef_responder_if;
  import hpf_coef_pkg::*;

  logic        n_1_reset;
  logic        en;
  logic        enable_reg_select;
  logic [1:0]  reg_select;
  coef_t       coefficient;
  sample_t     x;
  sample_t     y;
  logic        coef_valid;
  logic        cfg_error;

  modport master (
    output n_1_reset,
    output en,
    output enable_reg_select,
    output reg_select,
    output coefficient,
    output x,
    input  y,
    input  coef_valid,
    input  cfg_error
  );

  modport slave (
    input  n_1_reset,
    input  en,
    input  enable_reg_select,
    input  reg_select,
    input  coefficient,
    input  x,
    output y,
    output coef_valid,
    output cfg_error
  );

endinterface

// File: rtl/hpf_coef_shadow.sv
// Double-buffered coefficient store: shadow registers plus write mask, committed to the
// active set in a single cycle when the top-level FSM raises i_commit.
module hpf_coef_shadow
  import hpf_coef_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_wr_en,
  input  logic [1:0] i_wr_sel,
  input  coef_t     i_wr_data,
  input  logic      i_commit,
  output logic [2:0] o_mask,
  output coef_set_t o_active,
  output logic      o_coef_valid,
  output logic      o_cfg_error,
  output logic      o_legal_wr
);

  sel_e       w_sel;
  logic       w_legal_wr;
  logic       w_illegal_wr;
  logic [2:0] w_wr_bit;
  logic [2:0] w_mask_next;

  coef_set_t  r_shadow;
  coef_set_t  r_active;
  logic [2:0] r_mask;
  logic       r_coef_valid;
  logic       r_cfg_error;

  assign w_sel        = sel_e'(i_wr_sel);
  assign w_legal_wr   = i_wr_en && (w_sel != SEL_ILLEGAL);
  assign w_illegal_wr = i_wr_en && (w_sel == SEL_ILLEGAL);
  assign w_wr_bit     = w_legal_wr ? (3'b001 << i_wr_sel) : 3'b000;

  // A write landing in the commit cycle starts the next set with only its own bit.
  assign w_mask_next  = (i_commit ? 3'b000 : r_mask) | w_wr_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the coefficient registers are reset too, so a reset also discards any
      // half-loaded or previously active set rather than leaving stale values behind.
      r_shadow     <= '0;
      r_active     <= '0;
      r_mask       <= 3'b000;
      r_coef_valid <= 1'b0;
      r_cfg_error  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the commit copy the pre-write shadow even
      // when a write to the same register happens on the same edge.
      if (i_commit) begin
        r_active     <= r_shadow;
        r_coef_valid <= 1'b1;
      end
      if (w_legal_wr) begin
        case (w_sel)
          SEL_B0:  r_shadow.b0 <= i_wr_data;
          SEL_B1:  r_shadow.b1 <= i_wr_data;
          SEL_A1:  r_shadow.a1 <= i_wr_data;
          default: r_shadow    <= r_shadow;
        endcase
      end
      if (w_illegal_wr) begin
        r_cfg_error <= 1'b1;
      end
      r_mask <= w_mask_next;
    end
  end

  assign o_mask       = r_mask;
  assign o_active     = r_active;
  assign o_coef_valid = r_coef_valid;
  assign o_cfg_error  = r_cfg_error;
  assign o_legal_wr   = w_legal_wr;

endmodule

// File: rtl/hpf_coef_responder.sv
// First-order IIR responder y = b0*x + b1*x[n-1] + a1*y[n-1] with a double-buffered
// coefficient set. Define HPF_COEF_SATURATE_EN to clamp the output instead of wrapping.
module hpf_coef_responder
  import hpf_coef_pkg::*;
#(
  parameter int FRAC_SHIFT = 16
) (
  input logic                 clk,
  input logic                 reset,
  hpf_coef_responder_if.slave bus
);

  state_e     r_state;
  state_e     w_state_next;
  logic       w_commit;

  logic       w_legal_wr;
  logic [2:0] w_mask;
  coef_set_t  w_active;
  logic       w_coef_valid;
  logic       w_cfg_error;

  sample_t    r_x1;
  sample_t    r_y1;
  sample_t    r_y;
  sample_t    w_x1_use;
  sample_t    w_y1_use;
  acc_t       w_acc;
  sample_t    w_y_next;
  logic       w_run;

  hpf_coef_shadow u_shadow (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (bus.enable_reg_select),
    .i_wr_sel     (bus.reg_select),
    .i_wr_data    (bus.coefficient),
    .i_commit     (w_commit),
    .o_mask       (w_mask),
    .o_active     (w_active),
    .o_coef_valid (w_coef_valid),
    .o_cfg_error  (w_cfg_error),
    .o_legal_wr   (w_legal_wr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so every branch assigns every output and no latch is inferred.
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_legal_wr) w_state_next = LOAD;
      end
      LOAD: begin
        // Commit one cycle after the mask fills; a write in that cycle opens a new load.
        if (w_mask == MASK_ALL) begin
          w_commit     = 1'b1;
          w_state_next = w_legal_wr ? LOAD : ACTIVE;
        end
      end
      ACTIVE: begin
        if (w_legal_wr) w_state_next = LOAD;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_run = bus.en && w_coef_valid;

  always_comb begin
    w_x1_use = bus.n_1_reset ? '0 : r_x1;
    w_y1_use = bus.n_1_reset ? '0 : r_y1;
    w_acc    = acc_t'(mul(w_active.b0, bus.x))
             + acc_t'(mul(w_active.b1, w_x1_use))
             + acc_t'(mul(w_active.a1, w_y1_use));
  end

`ifdef HPF_COEF_SATURATE_EN
  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

  acc_t w_shifted;

  always_comb begin
    w_shifted = w_acc >>> FRAC_SHIFT;
    if (w_shifted > acc_t'(SAMPLE_MAX)) begin
      w_y_next = SAMPLE_MAX;
    end else if (w_shifted < acc_t'(SAMPLE_MIN)) begin
      w_y_next = SAMPLE_MIN;
    end else begin
      w_y_next = sample_t'(w_shifted);
    end
  end
`else
  // Keeping the low sample bits of the shifted sum wraps in two's complement on overflow.
  assign w_y_next = sample_t'(w_acc >>> FRAC_SHIFT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_y  <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
    end else if (w_run) begin
      r_y  <= w_y_next;
      r_x1 <= bus.x;
      r_y1 <= w_y_next;
    end else begin
      // Bypass: the sample passes straight through; n_1_reset only touches the history.
      r_y <= bus.x;
      if (bus.n_1_reset) begin
        r_x1 <= '0;
        r_y1 <= '0;
      end
    end
  end

  assign bus.y          = r_y;
  assign bus.coef_valid = w_coef_valid;
  assign bus.cfg_error  = w_cfg_error;

endmodule

// File: doc/hpf_coef_responder.md
HPF_COEF_RESPONDER -- requirements
Module: hpf_coef_responder

Interface
REQ-001 SHALL have parameter FRAC_SHIFT, default 16, meaning the fixed-point fraction bits of the coefficients.
REQ-002 SHALL have port clk, input, 1, the rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port n_1_reset, input, 1, which clears the x[n-1]/y[n-1] history only.
REQ-005 SHALL have port en, input, 1, the filter run enable.
REQ-006 SHALL have port enable_reg_select, input, 1, the coefficient write strobe.
REQ-007 SHALL have port reg_select, input, 2, the coefficient address: 0=b0, 1=b1, 2=a1, 3=illegal.
REQ-008 SHALL have port coefficient, input, 32 signed, the write data.
REQ-009 SHALL have port x, input, 16 signed, the sample in.
REQ-010 SHALL have port y, output, 16 signed, the registered sample out.
REQ-011 SHALL have port coef_valid, output, 1, high when an active coefficient set is committed.
REQ-012 SHALL have port cfg_error, output, 1, a sticky flag set on any illegal write.

Function
REQ-013 SHALL latch coefficient into the shadow[reg_select] register and set mask bit reg_select on each cycle where enable_reg_select=1 and reg_select!=3.
REQ-014 SHALL set cfg_error and leave shadow and mask unchanged on a write with reg_select=3.
REQ-015 SHALL have the FSM states IDLE, LOAD and ACTIVE.
REQ-016 SHALL use the following transitions: IDLE->LOAD on the first legal write; LOAD->ACTIVE on the cycle after mask==3'b111; ACTIVE->LOAD on any legal write.
REQ-017 SHALL, on the LOAD->ACTIVE transition, copy all three shadows to the active registers in one cycle, clear mask, and set coef_valid=1.
REQ-018 SHALL keep coef_valid=1 once it is set, until reset; a reload in LOAD keeps using the old active set until the new commit.
REQ-019 SHALL, on rewrites of the same address in LOAD, keep the last value and leave the mask unchanged.
REQ-020 SHALL compute, on a cycle with en=1 and coef_valid=1: acc = b0*x + b1*x1 + a1*y1, using a 50-bit signed accumulator on full 48-bit products.
REQ-021 SHALL register y <= acc >>> FRAC_SHIFT (arithmetic shift), then set x1 <= x and y1 <= y_next, with 1-cycle latency.
REQ-022 SHALL, when en=0 or coef_valid=0, register y <= x (bypass) and leave x1/y1 unchanged.
REQ-023 SHALL, when a write and en=1 occur in the same cycle, compute with the pre-write active set.
REQ-024 SHALL, when n_1_reset=1 and en=1 occur in the same cycle, use x1=y1=0 for that computation, then store the new history.
REQ-025 SHALL, when n_1_reset=1 and en=0, clear x1/y1 and keep the coefficients, state and y.

Reset
REQ-026 SHALL, on reset, force state=IDLE and mask=0, set shadow and active registers to 0, set x1=y1=0, y=0, coef_valid=0 and cfg_error=0.
REQ-027 SHALL let reset asserted mid-LOAD discard the partial set; the previously active set is also cleared.
REQ-028 SHALL give reset priority over n_1_reset, writes and en.

Configuration
REQ-029 SHALL, with macro HPF_COEF_SATURATE_EN defined, clamp acc >>> FRAC_SHIFT to [-32768, 32767] before registering y and y1.
REQ-030 SHALL, without HPF_COEF_SATURATE_EN, register bits [FRAC_SHIFT+15:FRAC_SHIFT] of acc (two's-complement wrap).

Structure
REQ-031 SHALL place the state enum, the reg_select codes (SEL_B0, SEL_B1, SEL_A1, SEL_ILLEGAL), and the sample/coefficient/accumulator widths in the shared package hpf_coef_pkg.
REQ-032 SHALL implement the shadow/mask/commit logic as one sub-module, hpf_coef_shadow; the MAC datapath and FSM stay in the top module.

Verification
REQ-033 SHALL check the 80 kHz load: write b0=0x0000FF00, b1=0xFFFF0100, a1=0x0000FE07 -> coef_valid=1 on the 4th cycle after the first write.
REQ-034 SHALL check the step response: with that set, hold x=1000 with en=1 -> y=996, then 988 on successive cycles.
REQ-035 SHALL check the illegal write: reg_select=3, data 0x12345678 -> cfg_error=1, mask unchanged, and no commit follows the other 2 writes.
REQ-036 SHALL check reload mid-run: with en=1, write b0=0 only -> y still follows the old set; after b1 and a1 are written, the new set applies on the commit cycle +1.
REQ-037 SHALL check n_1_reset and en together: x=1000 -> y=996 regardless of history.
REQ-038 SHALL check saturation: b0=0x7FFFFFFF, b1=a1=0, x=32767 -> y=32767 with HPF_COEF_SATURATE_EN, and acc[31:16] without it.
